// File: rtl/hv_bundle_acc.sv
// Bundling accumulator: folds per-lane signed {-1,0,+1} beats into saturating
// sums, then binarizes each sum by majority vote with an external tie-break.
module hv_bundle_acc #(
  parameter int unsigned CORE_NUM = 32,
  parameter int unsigned ACC_W    = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2*CORE_NUM-1:0] in_sel,
  input  logic [CORE_NUM-1:0]   tie_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CORE_NUM-1:0]   out_bits,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  err_illegal
);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, EMIT} state_e;

  state_e state_q, state_d;

  logic [CORE_NUM-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [CORE_NUM-1:0]            tie_q, tie_d;
  logic [CORE_NUM-1:0]            bits_q, bits_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           err_q, err_d;
  logic                           in_ready_q, in_ready_d;
  logic                           out_valid_q, out_valid_d;
  logic                           beat_acc;

  // in_ready_q mirrors state_q == ACCUM, so this is the handshake
  assign beat_acc = in_ready_q & in_valid;

  // Signed add of a {-1,0,+1} contribution, clamped to the accumulator range
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [1:0]       s);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {{(ACC_W-1){s[1]}}, s};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_add = sum[ACC_W-1:0];
    end
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (beat_acc && in_last) state_d = FINAL;
      FINAL:   state_d = EMIT;
      EMIT:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs, registered from the next state
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == ACCUM) in_ready_d = 1'b1;
    if (state_d == EMIT) out_valid_d = 1'b1;
  end

  // Lane datapath: clear on start, accumulate beats, binarize in FINAL
  always_comb begin
    acc_d  = acc_q;
    tie_d  = tie_q;
    bits_d = bits_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (state_q == IDLE && start) begin
      acc_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end
    if (beat_acc) begin
      for (int i = 0; i < int'(CORE_NUM); i++) begin
        if (in_sel[2*i +: 2] == 2'b10) begin
          err_d = 1'b1;
        end else begin
          acc_d[i] = sat_add(acc_q[i], in_sel[2*i +: 2]);
        end
      end
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      if (in_last) tie_d = tie_bits;
    end
    if (state_q == FINAL) begin
      for (int i = 0; i < int'(CORE_NUM); i++) begin
        if (acc_q[i][ACC_W-1]) begin
          bits_d[i] = 1'b1;
        end else if (acc_q[i] == '0) begin
          bits_d[i] = tie_q[i];
        end else begin
          bits_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      tie_q       <= '0;
      bits_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      tie_q       <= tie_d;
      bits_q      <= bits_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_bits    = bits_q;
  assign beat_count  = cnt_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_hv_bundle_acc.sv
// Bench for hv_bundle_acc: directed scenarios plus random bundles checked
// against an integer majority-vote model.
module tb_hv_bundle_acc;

  localparam int unsigned CN   = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned CW   = 4;
  localparam int          AMAX = 7;
  localparam int          AMIN = -8;
  localparam int          CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, in_last, out_valid, out_ready, err_illegal;
  logic [2*CN-1:0] in_sel;
  logic [CN-1:0] tie_bits, out_bits;
  logic [CW-1:0] beat_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int       m_acc [CN];
  int       m_cnt;
  bit       m_err;
  bit [CN-1:0] m_tie;

  hv_bundle_acc #(.CORE_NUM(CN), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_sel(in_sel),
    .tie_bits(tie_bits), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .beat_count(beat_count), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CN-1:0] m_bits();
    logic [CN-1:0] b;
    for (int i = 0; i < int'(CN); i++) begin
      if (m_acc[i] > 0)      b[i] = 1'b0;
      else if (m_acc[i] < 0) b[i] = 1'b1;
      else                   b[i] = m_tie[i];
    end
    return b;
  endfunction

  function automatic logic [1:0] enc(input int v);
    if (v > 0)       return 2'b01;
    else if (v < 0)  return 2'b11;
    else             return 2'b00;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < int'(CN); i++) m_acc[i] = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic m_reset();
    m_clear();
    m_tie = '0;
  endtask

  task automatic m_beat(input logic [2*CN-1:0] sel, input logic last, input logic [CN-1:0] tie);
    for (int i = 0; i < int'(CN); i++) begin
      logic [1:0] c;
      int v;
      c = sel[2*i +: 2];
      v = 0;
      if (c == 2'b01) v = 1;
      else if (c == 2'b11) v = -1;
      else if (c == 2'b10) m_err = 1'b1;
      m_acc[i] = m_acc[i] + v;
      if (m_acc[i] > AMAX) m_acc[i] = AMAX;
      if (m_acc[i] < AMIN) m_acc[i] = AMIN;
    end
    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    if (last) m_tie = tie;
  endtask

  task automatic begin_bundle(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    m_clear();
    chk({tag, "_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_cnt0"}, 32'(beat_count), 32'(0));
  endtask

  task automatic beat(input logic [2*CN-1:0] sel, input logic last, input logic [CN-1:0] tie);
    in_valid = 1'b1;
    in_sel   = sel;
    in_last  = last;
    tie_bits = tie;
    m_beat(sel, last, tie);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Call right after the last beat's edge: FINAL, then EMIT, then drain
  task automatic finish_bundle(input string tag);
    chk({tag, "_final_ov"}, 32'(out_valid), 32'(0));
    chk({tag, "_final_rdy"}, 32'(in_ready), 32'(0));
    step();
    chk({tag, "_ov"}, 32'(out_valid), 32'(1));
    chk({tag, "_bits"}, 32'(out_bits), 32'(m_bits()));
    chk({tag, "_cnt"}, 32'(beat_count), 32'(m_cnt));
    chk({tag, "_err"}, 32'(err_illegal), 32'(m_err));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_ov"}, 32'(out_valid), 32'(0));
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'(0));
    chk({tag, "_cnt_kept"}, 32'(beat_count), 32'(m_cnt));
  endtask

  initial begin
    logic [2*CN-1:0] s;
    logic [CN-1:0]   hold_bits;
    int              mode [CN];

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_sel = '0; tie_bits = '0; out_ready = 1'b0;
    m_reset();
    step(); step();
    rst_n = 1'b1;
    chk("rst_ov", 32'(out_valid), 32'(0));
    chk("rst_rdy", 32'(in_ready), 32'(0));
    chk("rst_bits", 32'(out_bits), 32'(0));
    chk("rst_cnt", 32'(beat_count), 32'(0));
    chk("rst_err", 32'(err_illegal), 32'(0));
    step();
    chk("idle_no_start", 32'(in_ready), 32'(0));

    // Basic majority
    begin_bundle("basic");
    beat({enc(1),  enc(0), enc(-1), enc(1)},  1'b0, 4'b0000);
    beat({enc(-1), enc(0), enc(-1), enc(1)},  1'b0, 4'b0000);
    beat({enc(0),  enc(0), enc(1),  enc(-1)}, 1'b1, 4'b0100);
    chk("basic_model", 32'(m_bits()), 32'(4'b0110));
    finish_bundle("basic");

    // Saturation: 10 x +1 pins at +7, 8 x -1 lands at -1
    begin_bundle("sat");
    for (int k = 0; k < 10; k++) beat({6'b0, enc(1)}, 1'b0, 4'b0000);
    for (int k = 0; k < 8; k++) beat({6'b0, enc(-1)}, k == 7, 4'b0000);
    chk("sat_model", 32'(m_bits()), 32'(4'b0001));
    chk("cnt_sat_model", 32'(m_cnt), 32'(15));
    finish_bundle("sat");

    // Backpressure with start ignored in EMIT
    begin_bundle("bp");
    beat({enc(1), enc(-1), enc(1), enc(-1)}, 1'b1, 4'b0000);
    step();
    hold_bits = m_bits();
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      chk("bp_hold_ov", 32'(out_valid), 32'(1));
      chk("bp_hold_bits", 32'(out_bits), 32'(hold_bits));
      step();
    end
    start = 1'b0;
    chk("bp_after_start_ov", 32'(out_valid), 32'(1));
    chk("bp_after_start_rdy", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle_ov", 32'(out_valid), 32'(0));
    step();
    chk("bp_still_idle", 32'(in_ready), 32'(0));

    // Illegal code on lane2 plus +1 on a later beat
    begin_bundle("ill");
    beat({enc(0), 2'b10, enc(0), enc(0)}, 1'b0, 4'b0000);
    beat({enc(0), enc(1), enc(0), enc(0)}, 1'b1, 4'b0000);
    chk("ill_model", 32'(m_bits()), 32'(4'b0000));
    finish_bundle("ill");
    begin_bundle("ill_clr");
    chk("ill_clr_err", 32'(err_illegal), 32'(0));
    beat({enc(0), enc(0), enc(0), enc(-1)}, 1'b1, 4'b1111);
    finish_bundle("ill_clr");

    // Reset mid-bundle, then a clean single-beat bundle
    begin_bundle("rmid");
    beat({enc(1), enc(1), enc(1), enc(1)}, 1'b0, 4'b0000);
    beat({enc(1), enc(1), enc(1), 2'b10}, 1'b0, 4'b0000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_reset();
    chk("rmid_ov", 32'(out_valid), 32'(0));
    chk("rmid_rdy", 32'(in_ready), 32'(0));
    chk("rmid_cnt", 32'(beat_count), 32'(0));
    chk("rmid_err", 32'(err_illegal), 32'(0));
    begin_bundle("rnew");
    beat({enc(0), enc(0), enc(0), enc(-1)}, 1'b1, 4'b1110);
    chk("rnew_model", 32'(m_bits()), 32'(4'b1111));
    finish_bundle("rnew");

    // Start coincident with the last beat is ignored
    begin_bundle("sol");
    beat({enc(1), enc(-1), enc(0), enc(1)}, 1'b0, 4'b0000);
    start = 1'b1;
    beat({enc(1), enc(-1), enc(0), enc(1)}, 1'b1, 4'b0010);
    start = 1'b0;
    finish_bundle("sol");
    step();
    chk("sol_stay_idle", 32'(in_ready), 32'(0));

    // Random bundles with idle gaps, stray in_last and occasional backpressure
    for (int b = 0; b < 30; b++) begin
      int len;
      begin_bundle("rnd");
      for (int i = 0; i < int'(CN); i++) mode[i] = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 20));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom);
          in_sel   = 8'($urandom);
          step();
          in_last  = 1'b0;
        end
        for (int i = 0; i < int'(CN); i++) begin
          int r;
          r = int'($urandom_range(0, 99));
          if (r < 3)                    s[2*i +: 2] = 2'b10;
          else if (mode[i] == 1)        s[2*i +: 2] = (r < 80) ? 2'b01 : 2'b11;
          else if (mode[i] == 2)        s[2*i +: 2] = (r < 80) ? 2'b11 : 2'b01;
          else                          s[2*i +: 2] = (r < 35) ? 2'b01 : (r < 70) ? 2'b11 : 2'b00;
        end
        beat(s, k == len - 1, 4'($urandom));
      end
      finish_bundle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so a stuck handshake still ends the run
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
